// File: rtl/dfd_cg_domain_ctrl.sv
// dfd_cg_domain_ctrl
// Per-domain clock-gating controller for the DFD debug/trace sub-blocks.
// One small FSM per domain watches activity, gates the domain through a
// generic_ccg (WIDTH=NUM_DOM) after a programmable idle window, and ungates
// it again through a req/ack handshake. Acknowledges only while the clock is stable.
//
// Optional feature: define DFD_CG_STATS_EN to add per-domain gated-cycle
// statistic counters (ports stat_clr / stat_gated_cnt). Without the macro the
// ports and counters do not exist and all other behaviour is unchanged.
//
// Handshake semantics (wake_req / wake_ack):
//   wake_req[i] is a level raised by a requester and held until it observes
//   wake_ack[i]=1. wake_ack[i] is 1 only while domain i is in RUN or IDLE,
//   i.e. its clock has been enabled for at least WAKE_CYC cycles. A requester
//   must not touch domain i while wake_ack[i]=0. Dropping wake_req early never
//   shortens or aborts a wake-up in progress.
//
// Per-domain state encoding (also visible on dbg_state, domain i at [2*i +: 2]):
//   0 RUN, 1 IDLE, 2 GATED, 3 WAKE

module dfd_cg_domain_ctrl #(
    parameter int NUM_DOM  = 4,
    parameter int THRESH_W = 8,
    parameter int WAKE_CYC = 3,
    parameter int STAT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DOM-1:0]    cfg_cg_enable,
    input  logic [THRESH_W-1:0]   cfg_idle_thresh,
    input  logic                  dbg_force_on,
    input  logic [NUM_DOM-1:0]    dom_busy,
    input  logic [NUM_DOM-1:0]    wake_req,
    output logic [NUM_DOM-1:0]    wake_ack,
    output logic [NUM_DOM-1:0]    ccg_en,
    output logic                  ccg_force_en,
    output logic [NUM_DOM-1:0]    dom_gated,
    output logic [2*NUM_DOM-1:0]  dbg_state
`ifdef DFD_CG_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NUM_DOM*STAT_W-1:0] stat_gated_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    // The counter is reused for the wake delay, so the wake constant must fit.
    localparam logic [THRESH_W-1:0] WAKE_LOAD = THRESH_W'(WAKE_CYC);
    localparam logic [THRESH_W-1:0] CNT_ONE   = THRESH_W'(1);

    state_e              state_q [NUM_DOM];
    state_e              state_d [NUM_DOM];
    logic [THRESH_W-1:0] cnt_q   [NUM_DOM];
    logic [THRESH_W-1:0] cnt_d   [NUM_DOM];
    logic [NUM_DOM-1:0]  hold;

    // Anything that needs the domain running keeps it out of (or pulls it from) the gated path.
    always_comb begin
        hold = dom_busy | wake_req | ~cfg_cg_enable | {NUM_DOM{dbg_force_on}};
    end

    // State and shared idle/wake counter registers for every domain.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DOM; i++) begin
            if (!rst_n) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state and counter update per domain; domains never interact.
    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_RUN: begin
                    if (!hold[i]) begin
                        if (cfg_idle_thresh == '0) begin
                            state_d[i] = ST_GATED;
                        end else begin
                            // Threshold is sampled only here; later changes wait for the next load.
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = cfg_idle_thresh;
                        end
                    end
                end
                ST_IDLE: begin
                    // Activity wins over an expiring count.
                    if (hold[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (cnt_q[i] == CNT_ONE) begin
                        state_d[i] = ST_GATED;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_GATED: begin
                    if (hold[i]) begin
                        state_d[i] = ST_WAKE;
                        cnt_d[i]   = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    // Not interruptible: the clock must settle before anyone is acked.
                    if (cnt_q[i] == CNT_ONE) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state flops.
    always_comb begin
        ccg_en    = '0;
        wake_ack  = '0;
        dom_gated = '0;
        dbg_state = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            ccg_en[i]          = (state_q[i] != ST_GATED);
            wake_ack[i]        = (state_q[i] == ST_RUN) || (state_q[i] == ST_IDLE);
            dom_gated[i]       = (state_q[i] == ST_GATED);
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    // Global force-enable to the CCG array: on out of reset, then follows the override one cycle late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccg_force_en <= 1'b1;
        end else begin
            ccg_force_en <= dbg_force_on;
        end
    end

`ifdef DFD_CG_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] stat_q [NUM_DOM];

    // Saturating gated-cycle counters; clear beats increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DOM; i++) begin
            if (!rst_n || stat_clr) begin
                stat_q[i] <= '0;
            end else if ((state_q[i] == ST_GATED) && (stat_q[i] != STAT_MAX)) begin
                stat_q[i] <= stat_q[i] + STAT_ONE;
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        stat_gated_cnt = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            stat_gated_cnt[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`endif

endmodule
